// File: rtl/fifo_package.sv
// fifo_package: shared widths and types for the SRAM-backed FIFO controller.
package fifo_package;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 8;
   localparam int unsigned SRAM_DEPTH = 256;
   localparam int unsigned OBUF_DEPTH = 2;

   // Owner of the most recent SRAM access, used for round-robin arbitration
   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } grant_e;

   // Occupancy count: SRAM words plus in-flight read plus output buffer
   typedef logic [ADDR_WIDTH+1:0] fifo_cnt_t;

endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 2-entry output buffer; head entry drives the consumer directly from a register.
module sram_fifo_obuf
   import fifo_package::*;
(
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            cnt_o
);

   logic [1:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;

   // Entry storage; a pop shifts tail into head, a push fills the first free slot
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else if (flush_i) begin
         r_cnt <= 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (r_cnt == 2'd0) r_head <= push_data_i;
               else               r_tail <= push_data_i;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_cnt  <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= push_data_i;
               end else begin
                  r_head <= push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid_o = (r_cnt != 2'd0);
   assign data_o  = r_head;
   assign cnt_o   = r_cnt;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: runs a single-port sync-read SRAM as a FIFO, arbitrating pushes against prefetch reads.
// Optional feature macro: SRAM_FIFO_BYPASS_EN (push goes straight to the output buffer when SRAM is empty).
module sram_fifo_ctrl
   import fifo_package::*;
(
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  out_ready_i,
   output fifo_cnt_t             count_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic                  sram_we_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
   fifo_cnt_t             r_mem_cnt, w_mem_cnt_nxt, r_count, w_count_nxt;
   logic                  r_inflight, w_inflight_nxt;
   grant_e                r_last_gnt, w_last_gnt_nxt;
   logic [1:0]            w_obuf_cnt, w_obuf_cnt_nxt;
   logic                  w_obuf_valid, w_obuf_push, w_pop, w_push_acc, w_bypass;
   logic                  w_rd_want, w_wr_full, w_in_ready, w_gnt_wr, w_gnt_rd;
   logic [DATA_WIDTH-1:0] w_obuf_wdata;

   // State registers
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_mem_cnt  <= '0;
         r_inflight <= 1'b0;
         r_last_gnt <= GNT_RD;
         r_count    <= '0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_mem_cnt  <= w_mem_cnt_nxt;
         r_inflight <= w_inflight_nxt;
         r_last_gnt <= w_last_gnt_nxt;
         r_count    <= w_count_nxt;
      end
   end

   // Arbitration, handshakes and next-state; flush overrides everything
   always_comb begin
      w_wr_ptr_nxt   = r_wr_ptr;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_last_gnt_nxt = r_last_gnt;

      w_wr_full  = (r_mem_cnt == fifo_cnt_t'(SRAM_DEPTH));
      w_rd_want  = (r_mem_cnt != '0) &&
                   ((fifo_cnt_t'(w_obuf_cnt) + fifo_cnt_t'(r_inflight)) < fifo_cnt_t'(OBUF_DEPTH));
      w_in_ready = rst_ni && !flush_i && !w_wr_full && !(w_rd_want && (r_last_gnt == GNT_WR));
      w_push_acc = in_valid_i && w_in_ready;
      w_pop      = w_obuf_valid && out_ready_i && !flush_i;
`ifdef SRAM_FIFO_BYPASS_EN
      w_bypass   = w_push_acc && (r_mem_cnt == '0) && !r_inflight && ((w_obuf_cnt != 2'd2) || w_pop);
`else
      w_bypass   = 1'b0;
`endif
      w_gnt_wr   = w_push_acc && !w_bypass;
      w_gnt_rd   = rst_ni && !flush_i && w_rd_want && !w_gnt_wr;

      // Returning read data has no conflict with bypass: bypass requires no read in flight
      w_obuf_push  = r_inflight || w_bypass;
      w_obuf_wdata = r_inflight ? sram_rdata_i : in_data_i;

      if (w_gnt_wr) begin
         w_last_gnt_nxt = GNT_WR;
         w_wr_ptr_nxt   = r_wr_ptr + ADDR_WIDTH'(1);
      end else if (w_gnt_rd) begin
         w_last_gnt_nxt = GNT_RD;
         w_rd_ptr_nxt   = r_rd_ptr + ADDR_WIDTH'(1);
      end

      w_mem_cnt_nxt  = r_mem_cnt + fifo_cnt_t'(w_gnt_wr) - fifo_cnt_t'(w_gnt_rd);
      w_inflight_nxt = w_gnt_rd;
      w_obuf_cnt_nxt = w_obuf_cnt + 2'(w_obuf_push) - 2'(w_pop);

      if (flush_i) begin
         w_wr_ptr_nxt   = '0;
         w_rd_ptr_nxt   = '0;
         w_mem_cnt_nxt  = '0;
         w_inflight_nxt = 1'b0;
         w_obuf_cnt_nxt = 2'd0;
         w_last_gnt_nxt = GNT_RD;
      end

      w_count_nxt = w_mem_cnt_nxt + fifo_cnt_t'(w_inflight_nxt) + fifo_cnt_t'(w_obuf_cnt_nxt);
   end

   // SRAM port: one access per cycle, idle port parks at address 0
   always_comb begin
      sram_we_o    = w_gnt_wr;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      if (w_gnt_wr) begin
         sram_addr_o  = r_wr_ptr;
         sram_wdata_o = in_data_i;
      end else if (w_gnt_rd) begin
         sram_addr_o  = r_rd_ptr;
      end
   end

   sram_fifo_obuf u_obuf (
      .clk         (clk),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (w_obuf_push),
      .push_data_i (w_obuf_wdata),
      .pop_i       (w_pop),
      .valid_o     (w_obuf_valid),
      .data_o      (out_data_o),
      .cnt_o       (w_obuf_cnt)
   );

   assign in_ready_o  = w_in_ready;
   assign out_valid_o = w_obuf_valid && !flush_i;
   assign count_o     = r_count;

endmodule
